// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_pkg
//  Description : Shared elaboration-time helpers for the serial sequence
//                detector: state-register width, KMP failure function and
//                the pattern-automaton next-state function.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_detect_pkg;

    // Largest supported pattern; patterns are zero-extended to this width
    // when handed to the helper functions.
    localparam int c_max_seq_len = 16;

    // Bits needed to encode states 0..seq_len, i.e. clog2(seq_len + 1).
    function automatic int state_width(input int seq_len);
        int w;
        int v;
        w = 0;
        v = seq_len;
        while (v > 0) begin
            w++;
            v = v >> 1;
        end
        if (w < 1) w = 1;
        return w;
    endfunction

    // Bit i of the pattern in arrival order (i = 0 is the first bit, the MSB).
    function automatic logic pat_bit(input logic [c_max_seq_len-1:0] pattern,
                                     input int seq_len, input int i);
        logic [c_max_seq_len-1:0] t;
        t = pattern >> (seq_len - 1 - i);
        return t[0];
    endfunction

    // Length of the longest proper prefix of pattern[0..k-1] that is also a
    // suffix of it.
    function automatic int fail(input logic [c_max_seq_len-1:0] pattern,
                                input int seq_len, input int k);
        int  res;
        bit  found;
        bit  ok;
        res   = 0;
        found = 1'b0;
        for (int l = k - 1; l >= 1; l--) begin
            if (!found) begin
                ok = 1'b1;
                for (int j = 0; j < l; j++) begin
                    if (pat_bit(pattern, seq_len, j) != pat_bit(pattern, seq_len, k - l + j))
                        ok = 1'b0;
                end
                if (ok) begin
                    res   = l;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Matched length after receiving bit b in state 'state'. State seq_len is
    // DETECT, which restarts from M0 or, when overlapping, from M(fail(seq_len)).
    // The result is the longest pattern prefix that is a suffix of the
    // received stream, which is exactly the KMP automaton transition.
    function automatic int next_state(input logic [c_max_seq_len-1:0] pattern,
                                      input int seq_len, input int overlap,
                                      input int state, input logic b);
        int  k;
        int  res;
        bit  found;
        bit  ok;
        k = state;
        if (state >= seq_len)
            k = (overlap != 0) ? fail(pattern, seq_len, seq_len) : 0;
        res   = 0;
        found = 1'b0;
        for (int l = k + 1; l >= 1; l--) begin
            if (!found) begin
                ok = (pat_bit(pattern, seq_len, l - 1) == b);
                for (int j = 0; j < l - 1; j++) begin
                    if (pat_bit(pattern, seq_len, j) != pat_bit(pattern, seq_len, k - l + 1 + j))
                        ok = 1'b0;
                end
                if (ok) begin
                    res   = l;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detect_param_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_match_counter
//  Description : Saturating up-counter; counts one per cycle with inc high
//                and sticks at all-ones instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Parameterised Moore serial-pattern detector (KMP automaton)
//                with optional saturating match counter.
//                Define SEQ_DETECT_CNT_EN to build the match counter;
//                otherwise match_count is tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
    parameter int                OVERLAP = 0,
    parameter int                CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             valid_in,
    output logic             out,
    output logic [CNT_W-1:0] match_count
);

    // State k = number of pattern bits matched; SEQ_LEN is DETECT.
    localparam int                          c_state_w   = state_width(SEQ_LEN);
    localparam int                          c_num_codes = 1 << c_state_w;
    localparam logic [c_max_seq_len-1:0]    c_pattern   = c_max_seq_len'(PATTERN);
    localparam logic [c_state_w-1:0]        c_st_m0     = '0;
    localparam logic [c_state_w-1:0]        c_st_detect = c_state_w'(SEQ_LEN);

    if ((SEQ_LEN < 2) || (SEQ_LEN > c_max_seq_len)) begin : g_bad_seq_len
        $error("seq_detect_param: SEQ_LEN=%0d outside legal range 2..16", SEQ_LEN);
    end

    logic [c_state_w-1:0] state_q;
    logic [c_state_w-1:0] state_d;

    // Transition table resolved at elaboration; unused codes fall back to M0.
    logic [c_state_w-1:0] w_nxt_on0 [c_num_codes];
    logic [c_state_w-1:0] w_nxt_on1 [c_num_codes];

    for (genvar s = 0; s < c_num_codes; s++) begin : g_next_tbl
        if (s <= SEQ_LEN) begin : g_used
            localparam logic [c_state_w-1:0] c_on0 =
                c_state_w'(next_state(c_pattern, SEQ_LEN, OVERLAP, s, 1'b0));
            localparam logic [c_state_w-1:0] c_on1 =
                c_state_w'(next_state(c_pattern, SEQ_LEN, OVERLAP, s, 1'b1));
            assign w_nxt_on0[s] = c_on0;
            assign w_nxt_on1[s] = c_on1;
        end else begin : g_unused
            assign w_nxt_on0[s] = c_st_m0;
            assign w_nxt_on1[s] = c_st_m0;
        end
    end

    // State register: async clear drops any partial match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= c_st_m0;
        else        state_q <= state_d;
    end

    // Next state: advance only on accepted bits, hold otherwise.
    always_comb begin
        state_d = state_q;
        if (valid_in)
            state_d = data_in ? w_nxt_on1[state_q] : w_nxt_on0[state_q];
    end

    // Moore output: depends on the state register only.
    always_comb begin
        out = (state_q == c_st_detect);
    end

`ifdef SEQ_DETECT_CNT_EN
    logic w_inc;
    assign w_inc = valid_in && (state_d == c_st_detect);

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_match_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc),
        .count (match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN [SEQ_LEN-1:0], default 4'b1011: target sequence, MSB received first.
REQ-003 SHALL have parameter OVERLAP, default 0: 0 = non-overlapping detection, 1 = overlapping detection.
REQ-004 SHALL have parameter CNT_W, default 8: match-counter width.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port data_in  input  1  serial data bit.
REQ-008 SHALL have port valid_in  input  1  data_in is sampled only when high.
REQ-009 SHALL have port out  output  1  Moore detect flag, high while the FSM is in DETECT.
REQ-010 SHALL have port match_count  output  CNT_W  saturating count of detections.

Function
REQ-011 SHALL implement a Moore FSM with states M0..M(SEQ_LEN-1), where Mk means k pattern bits are matched, plus DETECT (= SEQ_LEN matched).
REQ-012 SHALL advance the FSM only on a rising clk edge with valid_in=1; with valid_in=0, state, out and match_count SHALL hold.
REQ-013 SHALL, from Mk on a bit equal to the next expected pattern bit, go to M(k+1), or to DETECT when k=SEQ_LEN-1.
REQ-014 SHALL, from Mk on a mismatching bit, go to the longest proper pattern prefix that is a suffix of the received bits (KMP failure rule), not unconditionally to M0.
REQ-015 SHALL, from DETECT with OVERLAP=0, process the incoming bit as from M0.
REQ-016 SHALL, from DETECT with OVERLAP=1, process the incoming bit as from M(fail(SEQ_LEN)), where fail(SEQ_LEN) is the longest proper prefix that is also a suffix of PATTERN.
REQ-017 SHALL drive out=1 exactly when state=DETECT; out is a pure function of the state register, with no combinational path from data_in or valid_in.
REQ-018 SHALL assert out in the cycle following the edge that samples the final pattern bit (latency 1 clk); out SHALL stay high until the next accepted bit.
REQ-019 SHALL allow back-to-back DETECT (DETECT -> DETECT), e.g. pattern 111 with OVERLAP=1 and continuous 1s.
REQ-020 SHALL increment match_count by 1 on every accepted edge whose next state is DETECT, saturating at 2^CNT_W-1 (no wrap).

Reset
REQ-021 SHALL, on rst_n=0 and independent of clk, force state=M0, out=0 and match_count=0.
REQ-022 SHALL discard any partial match on reset mid-sequence; the first accepted bit after rst_n deasserts is evaluated from M0.

Configuration
REQ-023 SHALL, with SEQ_DETECT_CNT_EN defined, implement match_count per REQ-020.
REQ-024 SHALL, without SEQ_DETECT_CNT_EN, tie match_count to constant 0, remove the counter logic, and leave FSM and out behaviour unchanged.

Structure
REQ-025 SHALL place the state-width constant function (clog2(SEQ_LEN+1)) and the elaboration-time functions fail() and next_state() in shared package seq_detect_pkg.
REQ-026 SHALL implement the saturating counter as sub-module seq_match_counter (parameter CNT_W; inputs clk, rst_n, inc; output count).
REQ-027 SHALL reject SEQ_LEN outside 2..16 with an elaboration-time error.

Verification
REQ-028 Defaults, valid_in=1, bits 1,0,1,1,0,1,1 -> out high only after bit 4; match_count=1.
REQ-029 OVERLAP=1, same bits 1,0,1,1,0,1,1 -> out high after bit 4 and after bit 7; match_count=2.
REQ-030 Defaults, bits 1,0, valid_in=0 for 3 cycles, then bits 1,1 -> out high after the final 1; out and state held during the gap.
REQ-031 Defaults, bits 1,0,1, then rst_n low for 1 cycle, then bit 1 -> no detect; out=0, match_count=0.
REQ-032 SEQ_LEN=3, PATTERN=3'b111, OVERLAP=1, bits 1,1,1,1,1 -> out high for 3 consecutive cycles; match_count=3.
REQ-033 CNT_W=2, 5 non-overlapping matches of 1011 -> match_count saturates at 3; repeat with SEQ_DETECT_CNT_EN undefined -> match_count=0 throughout.
